// File: rtl/cpu_pkg.sv
// Shared definitions for the execute stage: ALU op codes, the control FSM
// state type, datapath width and iteration count of the multiply/divide
// engine.
// Optional feature: EXECUTE_DIV_EN enables the iterative unsigned divider
// (adds the DIV state); when undefined, op 10 is a single-cycle zero result.
package cpu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ITER_N = 16;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_SLT = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;
  localparam logic [3:0] OP_DIV = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
`ifdef EXECUTE_DIV_EN
    ST_DIV  = 2'd2,
`endif
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/iter_muldiv.sv
// Iterative multiply/divide engine, one bit per cycle for ITER_N cycles.
// Multiply: shift-add, low DATA_W bits of the product.
// Divide (EXECUTE_DIV_EN only): restoring division, unsigned quotient;
// a zero divisor naturally yields an all-ones quotient.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   start     - load operands and begin iterating (ignored mid-operation
//               by construction: the caller only starts from idle)
//   op        - 0 multiply, 1 divide
//   a, b      - multiplicand/dividend, multiplier/divisor
//   done      - high during the cycle whose edge performs the last iteration
//   result    - final value, held until the next start
module iter_muldiv
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int unsigned     CNT_W    = $clog2(ITER_N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_N - 1);

  // mc: multiplicand (shifts left) or divisor (static)
  // sh: multiplier (shifts right) or dividend shifting out / quotient in
  // acc: product accumulator or partial remainder
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_q, op_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mc_q, mc_d;
  logic [DATA_W-1:0] sh_q, sh_d;
`ifdef EXECUTE_DIV_EN
  logic [DATA_W:0]   rem_sh, diff;
`endif

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    acc_d  = acc_q;
    mc_d   = mc_q;
    sh_d   = sh_q;
`ifdef EXECUTE_DIV_EN
    rem_sh = '0;
    diff   = '0;
`endif
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      op_d   = op;
      acc_d  = '0;
      mc_d   = b;
      sh_d   = a;
    end else if (busy_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) busy_d = 1'b0;
`ifdef EXECUTE_DIV_EN
      if (op_q) begin
        // Borrow out of the 17-bit subtract means remainder < divisor.
        rem_sh = {acc_q, sh_q[DATA_W-1]};
        diff   = rem_sh - {1'b0, mc_q};
        if (!diff[DATA_W]) begin
          acc_d = diff[DATA_W-1:0];
          sh_d  = {sh_q[DATA_W-2:0], 1'b1};
        end else begin
          acc_d = rem_sh[DATA_W-1:0];
          sh_d  = {sh_q[DATA_W-2:0], 1'b0};
        end
      end else
`endif
      begin
        if (sh_q[0]) acc_d = acc_q + mc_q;
        mc_d = {mc_q[DATA_W-2:0], 1'b0};
        sh_d = {1'b0, sh_q[DATA_W-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= 1'b0;
      acc_q  <= '0;
      mc_q   <= '0;
      sh_q   <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      acc_q  <= acc_d;
      mc_q   <= mc_d;
      sh_q   <= sh_d;
    end
  end

  assign done = busy_q && (cnt_q == CNT_LAST);
`ifdef EXECUTE_DIV_EN
  assign result = op_q ? sh_q : acc_q;
`else
  assign result = op_q ? '0 : acc_q;
`endif

endmodule

// File: rtl/execute_stage.sv
// Pipeline execute stage: single-cycle ALU, control FSM for iterative
// MUL/DIV, and the output register feeding the memory stage.
// Optional feature: EXECUTE_DIV_EN enables iterative DIV (op 10);
// otherwise op 10 is a single-cycle op returning zero.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   Stall              - holds the output register (iteration continues)
//   InValid, AluOp     - instruction present, operation select
//   OpA, OpB           - operands (OpB already immediate-muxed)
//   StoreData, MemWrIn - store value and store flag
//   ALUResult, DataIn, MemWr, OutValid - registered outputs
//   Busy               - combinational; upstream must freeze while high
module execute_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall,
  input  logic              InValid,
  input  logic [3:0]        AluOp,
  input  logic [DATA_W-1:0] OpA,
  input  logic [DATA_W-1:0] OpB,
  input  logic [DATA_W-1:0] StoreData,
  input  logic              MemWrIn,
  output logic [DATA_W-1:0] ALUResult,
  output logic [DATA_W-1:0] DataIn,
  output logic              MemWr,
  output logic              OutValid,
  output logic              Busy
);

  state_e            state_q, state_d;
  logic              is_mul, is_div, multi, accept, eng_start, eng_done;
  logic [DATA_W-1:0] alu_res, eng_result;
  logic [DATA_W-1:0] res_q, res_d, data_q, data_d, sdata_q, sdata_d;
  logic              memwr_q, memwr_d, valid_q, valid_d, smw_q, smw_d;

  assign is_mul = (AluOp == OP_MUL);
`ifdef EXECUTE_DIV_EN
  assign is_div = (AluOp == OP_DIV);
`else
  assign is_div = 1'b0;
`endif
  assign multi     = is_mul || is_div;
  assign accept    = (state_q == ST_IDLE) && InValid && !Stall;
  assign eng_start = accept && multi;
  assign Busy      = (state_q != ST_IDLE) || (InValid && multi);

  iter_muldiv u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (eng_start),
    .op     (is_div),
    .a      (OpA),
    .b      (OpB),
    .done   (eng_done),
    .result (eng_result)
  );

  always_comb begin
    alu_res = '0;
    case (AluOp)
      OP_ADD: alu_res = OpA + OpB;
      OP_SUB: alu_res = OpA - OpB;
      OP_AND: alu_res = OpA & OpB;
      OP_OR:  alu_res = OpA | OpB;
      OP_XOR: alu_res = OpA ^ OpB;
      OP_SLL: alu_res = OpA << OpB[3:0];
      OP_SRL: alu_res = OpA >> OpB[3:0];
      OP_SRA: alu_res = $unsigned($signed(OpA) >>> OpB[3:0]);
      OP_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(OpA) < $signed(OpB))};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    data_d  = data_q;
    memwr_d = memwr_q;
    valid_d = valid_q;
    sdata_d = sdata_q;
    smw_d   = smw_q;
    case (state_q)
      ST_IDLE: begin
        if (!Stall) begin
          if (InValid && !multi) begin
            res_d   = alu_res;
            data_d  = StoreData;
            memwr_d = MemWrIn;
            valid_d = 1'b1;
          end else begin
            // Idle cycle or acceptance of a multi-cycle op: bubble
            valid_d = 1'b0;
            memwr_d = 1'b0;
          end
        end
        if (eng_start) begin
          sdata_d = StoreData;
          smw_d   = MemWrIn;
        end
        if (accept && is_mul) state_d = ST_MUL;
`ifdef EXECUTE_DIV_EN
        else if (accept && is_div) state_d = ST_DIV;
`endif
      end
`ifdef EXECUTE_DIV_EN
      ST_MUL, ST_DIV: begin
`else
      ST_MUL: begin
`endif
        if (!Stall) begin
          valid_d = 1'b0;
          memwr_d = 1'b0;
        end
        if (eng_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!Stall) begin
          res_d   = eng_result;
          data_d  = sdata_q;
          memwr_d = smw_q;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      data_q  <= '0;
      memwr_q <= 1'b0;
      valid_q <= 1'b0;
      sdata_q <= '0;
      smw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      data_q  <= data_d;
      memwr_q <= memwr_d;
      valid_q <= valid_d;
      sdata_q <= sdata_d;
      smw_q   <= smw_d;
    end
  end

  assign ALUResult = res_q;
  assign DataIn    = data_q;
  assign MemWr     = memwr_q;
  assign OutValid  = valid_q;

endmodule
